// File: rtl/add_share_arb_if.sv
// Bundle for add_share_arb: request side, shared-adder drive, and result register.
// The arbiter takes the slave modport; the environment drives the master side.
interface add_share_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int TAG_W      = 5,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic                          flush;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [2*NUM_REQ-1:0]          req_add_type;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_src1;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_src2;
  logic [21*NUM_REQ-1:0]         req_imm;
  logic [TAG_W*NUM_REQ-1:0]      req_tag;

  logic [1:0]                    add_type_o;
  logic [DATA_WIDTH-1:0]         add_src1_o;
  logic [DATA_WIDTH-1:0]         add_src2_o;
  logic [20:0]                   add_imm_o;
  logic [DATA_WIDTH-1:0]         add_sum_i;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]               rsp_id;
  logic [TAG_W-1:0]              rsp_tag;

  modport slave (
    input  flush, req_valid, req_add_type, req_src1, req_src2, req_imm, req_tag,
           add_sum_i, rsp_ready,
    output req_ready, add_type_o, add_src1_o, add_src2_o, add_imm_o,
           rsp_valid, rsp_data, rsp_id, rsp_tag
  );

  modport master (
    output flush, req_valid, req_add_type, req_src1, req_src2, req_imm, req_tag,
           add_sum_i, rsp_ready,
    input  req_ready, add_type_o, add_src1_o, add_src2_o, add_imm_o,
           rsp_valid, rsp_data, rsp_id, rsp_tag
  );
endinterface

// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one combinational adder among NUM_REQ requesters,
// with a one-entry result register. Optional feature macro: ADD_ARB_PRIO0_EN.
module add_share_arb #(
  parameter int NUM_REQ    = 4,
  parameter int TAG_W      = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  add_share_arb_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic                  canIssue;
  logic                  found;
  logic                  grant;
  logic [ID_W:0]         cand;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       rrPtr_q, rrPtr_d;
  logic                  rspValid_q, rspValid_d;
  logic [DATA_WIDTH-1:0] rspData_q, rspData_d;
  logic [ID_W-1:0]       rspId_q, rspId_d;
  logic [TAG_W-1:0]      rspTag_q, rspTag_d;

  // A grant only happens when the result slot is free or draining this cycle.
  assign canIssue = !reset && !bus.flush && (!rspValid_q || bus.rsp_ready);

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
`ifdef ADD_ARB_PRIO0_EN
    if (bus.req_valid[0]) found = 1'b1;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rrPtr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grant          = canIssue && found;
    bus.req_ready  = '0;
    bus.add_type_o = '0;
    bus.add_src1_o = '0;
    bus.add_src2_o = '0;
    bus.add_imm_o  = '0;
    if (grant) begin
      bus.req_ready[winner] = 1'b1;
      bus.add_type_o = bus.req_add_type[2*winner +: 2];
      bus.add_src1_o = bus.req_src1[DATA_WIDTH*winner +: DATA_WIDTH];
      bus.add_src2_o = bus.req_src2[DATA_WIDTH*winner +: DATA_WIDTH];
      bus.add_imm_o  = bus.req_imm[21*winner +: 21];
    end
  end

  always_comb begin
    rrPtr_d    = rrPtr_q;
    rspValid_d = rspValid_q;
    rspData_d  = rspData_q;
    rspId_d    = rspId_q;
    rspTag_d   = rspTag_q;
    if (grant) begin
      rspValid_d = 1'b1;
      rspData_d  = bus.add_sum_i;
      rspId_d    = winner;
      rspTag_d   = bus.req_tag[TAG_W*winner +: TAG_W];
    end else if (bus.flush || bus.rsp_ready) begin
      rspValid_d = 1'b0;
    end
    // With fixed priority on port 0, only the shared ports move the pointer.
`ifdef ADD_ARB_PRIO0_EN
    if (grant && winner != '0)
`else
    if (grant)
`endif
      rrPtr_d = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr_q    <= '0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      rspId_q    <= '0;
      rspTag_q   <= '0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      rspId_q    <= rspId_d;
      rspTag_q   <= rspTag_d;
    end
  end

  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_data  = rspData_q;
  assign bus.rsp_id    = rspId_q;
  assign bus.rsp_tag   = rspTag_q;
endmodule

// File: tb/tb_add_share_arb.sv
// Directed testbench for add_share_arb with a behavioural model of the shared adder.
// Build with ADD_ARB_PRIO0_EN defined to exercise the fixed-priority variant.
module tb_add_share_arb;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 5;
  localparam int DW      = 32;
  localparam logic [1:0] CTRL_ADD  = 2'b00;
  localparam logic [1:0] CTRL_SUB  = 2'b01;
  localparam logic [1:0] CTRL_ADDI = 2'b10;

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   errorCount = 0;

  add_share_arb_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_WIDTH(DW)) bus ();

  add_share_arb #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // The shared adder; an unknown control code passes src1 through.
  always_comb begin
    case (bus.add_type_o)
      CTRL_ADD:  bus.add_sum_i = bus.add_src1_o + bus.add_src2_o;
      CTRL_SUB:  bus.add_sum_i = bus.add_src1_o - bus.add_src2_o;
      CTRL_ADDI: bus.add_sum_i = bus.add_src1_o + {{11{bus.add_imm_o[20]}}, bus.add_imm_o};
      default:   bus.add_sum_i = bus.add_src1_o;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] t, input logic [31:0] s1,
                               input logic [31:0] s2, input logic [20:0] imm,
                               input logic [4:0] tag);
    bus.req_add_type[idx*2 +: 2]   = t;
    bus.req_src1[idx*DW +: DW]     = s1;
    bus.req_src2[idx*DW +: DW]     = s2;
    bus.req_imm[idx*21 +: 21]      = imm;
    bus.req_tag[idx*TAG_W +: TAG_W] = tag;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRsp(input string tag, input logic v, input logic [31:0] data,
                          input logic [31:0] id, input logic [31:0] rtag);
    checkOutput({tag, ".valid"}, 32'(bus.rsp_valid), 32'(v));
    checkOutput({tag, ".data"}, bus.rsp_data, data);
    checkOutput({tag, ".id"}, 32'(bus.rsp_id), id);
    checkOutput({tag, ".tag"}, 32'(bus.rsp_tag), rtag);
  endtask

  initial begin
    reset            = 1'b1;
    bus.flush        = 1'b0;
    bus.rsp_ready    = 1'b1;
    bus.req_valid    = '0;
    bus.req_add_type = '0;
    bus.req_src1     = '0;
    bus.req_src2     = '0;
    bus.req_imm      = '0;
    bus.req_tag      = '0;
    applyStimulus(0, CTRL_ADD,  32'd1,         32'd1, 21'd0, 5'd10);
    applyStimulus(1, CTRL_ADD,  32'd5,         32'd7, 21'd0, 5'd11);
    applyStimulus(2, CTRL_SUB,  32'd10,        32'd3, 21'd0, 5'd12);
    applyStimulus(3, CTRL_ADDI, 32'hFFFF_FFFF, 32'd0, 21'd1, 5'd13);
    bus.req_valid = 4'b1111;
    #2;
    checkOutput("resetReqReady", 32'(bus.req_ready), 32'd0);
    checkOutput("resetAddSrc1", bus.add_src1_o, 32'd0);
    checkOutput("resetAddType", 32'(bus.add_type_o), 32'd0);
    nextCycle();
    checkRsp("resetRsp", 1'b0, 32'd0, 32'd0, 32'd0);
    reset = 1'b0;

`ifdef ADD_ARB_PRIO0_EN
    bus.req_valid = 4'b0101;
    repeat (3) begin
      #1;
      checkOutput("prio0Grant", 32'(bus.req_ready), 32'd1);
      nextCycle();
      checkRsp("prio0Rsp", 1'b1, 32'd2, 32'd0, 32'd10);
    end
    bus.req_valid = 4'b0100;
    #1;
    checkOutput("prio0DropGrant", 32'(bus.req_ready), 32'd4);
    nextCycle();
    checkRsp("prio0DropRsp", 1'b1, 32'd7, 32'd2, 32'd12);
`else
    begin
      logic [3:0]  expGrant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [31:0] expData  [5] = '{32'd2, 32'd12, 32'd7, 32'd0, 32'd2};
      logic [31:0] expTag   [5] = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd10};
      for (int c = 0; c < 5; c++) begin
        #1;
        checkOutput("rrGrant", 32'(bus.req_ready), 32'(expGrant[c]));
        if (c == 1) begin
          checkOutput("muxSrc1", bus.add_src1_o, 32'd5);
          checkOutput("muxSrc2", bus.add_src2_o, 32'd7);
        end
        nextCycle();
        checkRsp("rrRsp", 1'b1, expData[c], 32'(c % 4), expTag[c]);
      end
    end

    bus.rsp_ready = 1'b0;
    repeat (3) begin
      #1;
      checkOutput("holdReqReady", 32'(bus.req_ready), 32'd0);
      checkOutput("holdAddSrc1", bus.add_src1_o, 32'd0);
      nextCycle();
      checkRsp("holdRsp", 1'b1, 32'd2, 32'd0, 32'd10);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("resumeGrant", 32'(bus.req_ready), 32'd2);
    nextCycle();
    checkRsp("resumeRsp", 1'b1, 32'd12, 32'd1, 32'd11);

    bus.req_valid = 4'b0001;
    bus.flush     = 1'b1;
    #1;
    checkOutput("flushNoGrant", 32'(bus.req_ready), 32'd0);
    nextCycle();
    checkOutput("flushRspValid", 32'(bus.rsp_valid), 32'd0);
    bus.flush = 1'b0;
    #1;
    checkOutput("postFlushGrant", 32'(bus.req_ready), 32'd1);
    nextCycle();
    checkRsp("postFlushRsp", 1'b1, 32'd2, 32'd0, 32'd10);

    applyStimulus(1, 2'b11, 32'd100, 32'd55, 21'd0, 5'd21);
    bus.req_valid = 4'b0010;
    #1;
    checkOutput("unkGrant", 32'(bus.req_ready), 32'd2);
    checkOutput("unkAddType", 32'(bus.add_type_o), 32'd3);
    nextCycle();
    checkRsp("unkRsp", 1'b1, 32'd100, 32'd1, 32'd21);

    bus.req_valid = 4'b1010;
    reset = 1'b1;
    #1;
    checkOutput("resetGrantReady", 32'(bus.req_ready), 32'd0);
    nextCycle();
    checkRsp("resetGrantRsp", 1'b0, 32'd0, 32'd0, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("postResetGrant", 32'(bus.req_ready), 32'd2);
    nextCycle();
    checkRsp("postResetRsp", 1'b1, 32'd100, 32'd1, 32'd21);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/add_share_arb.md
# add_share_arb

Round-robin arbiter and sequencer that time-shares the single combinational integer adder (ADD/SUB/ADDI) among `NUM_REQ` execution-side requesters. Examples are the ALU issue port, the branch-target calculator and the load/store address generator. It selects at most one request per cycle and drives the adder operand/control inputs. The sum, requester ID and tag are captured into a one-entry output register with valid/ready back-pressure. It sits between the issue stage and the writeback/result bus.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `TAG_W`, 5, width of per-request tag (e.g. destination register index)
- `DATA_WIDTH`, from system parameters (32), operand/result width
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  reset, synchronous, active-high
- `flush`  in  1  pipeline flush; kills buffered result and blocks grant this cycle
- `req_valid`  in  NUM_REQ  request valid per requester
- `req_ready`  out  NUM_REQ  one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`
- `req_add_type`  in  2*NUM_REQ  per-requester control: `CTRL_ADD`/`CTRL_SUB`/`CTRL_ADDI`
- `req_src1`, `req_src2`  in  DATA_WIDTH*NUM_REQ  per-requester operands
- `req_imm`  in  21*NUM_REQ  per-requester immediate (ADDI only)
- `req_tag`  in  TAG_W*NUM_REQ  per-requester tag
- `add_type_o`, `add_src1_o`, `add_src2_o`, `add_imm_o`  out  2/DW/DW/21  drive the shared adder; zero when no grant
- `add_sum_i`  in  DATA_WIDTH  adder result (combinational, same cycle)
- `rsp_valid`  out  1  output register holds a result
- `rsp_ready`  in  1  consumer accepts result
- `rsp_data`  out  DATA_WIDTH  registered sum
- `rsp_id`  out  $clog2(NUM_REQ)  index of requester that produced it
- `rsp_tag`  out  TAG_W  tag of that request

## Operation
- `can_issue = !flush & (!rsp_valid | rsp_ready)`. No grant when `can_issue` is 0, and `req_ready` is then all zero.
- Round-robin pointer `rr_ptr` (log2 NUM_REQ bits). Search for a valid request starting at `rr_ptr`, wrapping modulo NUM_REQ. The first valid requester found wins.
- `req_ready` is one-hot on the winner and depends only on `req_valid`, `rr_ptr`, `rsp_valid`, `rsp_ready` and `flush`. It does not depend on operand data.
- The winner's type, sources and immediate are muxed to `add_*_o`. `add_sum_i` is captured into `rsp_data`, and the winner's index and tag go to `rsp_id`/`rsp_tag`.
- `rr_ptr` moves to winner+1 (with wrap) on every accepted grant. It holds when there is no grant.
- Output register:
  - Load on grant.
  - Else clear `rsp_valid` when `rsp_ready`.
  - Else hold with data stable.
  - A simultaneous drain and grant loads the new result, so full throughput is kept.
- `flush`: `rsp_valid` goes to 0 next cycle whatever `rsp_ready` is. There is no grant in the flush cycle. `rr_ptr` is held.
- Unknown `add_type` (2'b11) is still granted and forwarded. The adder returns src1+0.

## Timing
- Latency: grant in cycle N produces `rsp_valid`=1 in cycle N+1.
- Throughput: one result per cycle while `rsp_ready`=1.
- Back-pressure: with `rsp_valid`=1 and `rsp_ready`=0, `req_ready`=0 and `rsp_*` are held.
- Reset values:
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_tag`=0, `rr_ptr`=0.
  - `req_ready`=0 and `add_*_o`=0 during the reset cycle.
- Reset during a held result drops that result. Reset has priority over flush and grant.
- Requesters must hold valid and payload until accepted. The arbiter never grants a requester whose `req_valid`=0.

## Configuration
- `ADD_ARB_PRIO0_EN`
  - Defined: requester 0 is a fixed highest-priority port and wins whenever valid. Requesters 1..NUM_REQ-1 are round-robin among themselves when requester 0 is idle. `rr_ptr` only advances on grants to 1..NUM_REQ-1.
  - Undefined: pure round-robin across all NUM_REQ ports.

## Test plan
- Reset, then all four valid every cycle with `rsp_ready`=1 → grants 0,1,2,3,0 in consecutive cycles. `rsp_id` follows one cycle later. ADD 5+7 on req1 gives `rsp_data`=12.
- Req2 SUB src1=10, src2=3, and req3 ADDI src1=0xFFFFFFFF, imm=1 → `rsp_data`=7 and then 0x00000000 (wrap), with tags carried.
- Hold result with `rsp_ready`=0 for 3 cycles while all valid → `req_ready`=0, `rsp_*` stable. After release, the next grant resumes from the correct `rr_ptr`.
- Flush asserted with `rsp_valid`=1 and req0 valid → next cycle `rsp_valid`=0, no grant in the flush cycle. Req0 is granted in the following cycle.
- Reset asserted in the same cycle as a grant → next cycle all outputs are 0, `rr_ptr`=0, and the first subsequent grant goes to the lowest valid index.
- `ADD_ARB_PRIO0_EN` defined, req0 and req2 continuously valid → req0 granted every cycle. Drop req0 → req2 granted.
